// File: rtl/gray_pkg.sv
// Shared mode encodings for the Gray-code stream codec.
package gray_pkg;

  typedef enum logic [1:0] {
    MODE_G2B   = 2'b00,
    MODE_B2G   = 2'b01,
    MODE_COUNT = 2'b10,
    MODE_CHECK = 2'b11
  } mode_e;

endpackage

// File: rtl/gray_bin_xor.sv
// Combinational binary<->Gray converter; to_bin selects Gray-to-binary.
module gray_bin_xor #(
  parameter int W = 8
) (
  input  logic [W-1:0] din,
  input  logic         to_bin,
  output logic [W-1:0] dout
);

  always_comb begin
    dout = din ^ (din >> 1);
    // Binary bit i is the XOR of all Gray bits at or above i.
    if (to_bin) begin
      for (int unsigned i = 0; i < W; i++) begin
        dout[i] = ^(din >> i);
      end
    end
  end

endmodule

// File: rtl/gray_codec_stream.sv
// Valid/ready Gray-code codec with a one-entry output register, a Gray
// counter mode and a single-bit-change checker.
module gray_codec_stream
  import gray_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   mode,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_err
);

  mode_e        mode_sel;
  logic [W-1:0] cnt;
  logic [W-1:0] last_chk;
  logic         first_chk;
  logic         accept;
  logic [W-1:0] xor_in;
  logic [W-1:0] xor_out;
  logic [W-1:0] result;
  logic         result_err;

  assign mode_sel = mode_e'(mode);
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // The counter shares the converter in binary-to-Gray direction.
  assign xor_in = (mode_sel == MODE_COUNT) ? cnt : in_data;

  gray_bin_xor #(.W(W)) u_xor (
    .din   (xor_in),
    .to_bin(mode_sel == MODE_G2B),
    .dout  (xor_out)
  );

  always_comb begin
    result     = xor_out;
    result_err = 1'b0;
    if (mode_sel == MODE_CHECK) begin
      result     = in_data;
      result_err = !first_chk && !$onehot(in_data ^ last_chk);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
      cnt       <= '0;
      last_chk  <= '0;
      first_chk <= 1'b1;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= result;
      out_err   <= result_err;
      if (mode_sel == MODE_COUNT) begin
        cnt <= cnt + 1'b1;
      end
      if (mode_sel == MODE_CHECK) begin
        last_chk  <= in_data;
        first_chk <= 1'b0;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gray_codec_stream.sv
// Self-checking bench for gray_codec_stream (W=4) against a behavioural model.
module tb_gray_codec_stream;
  import gray_pkg::*;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         out_err;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state
  logic         m_valid;
  logic [W-1:0] m_data;
  logic         m_err;
  int           m_cnt;
  logic [W-1:0] m_last;
  logic         m_first;

  gray_codec_stream #(.W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mode     (mode),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_err  (out_err)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] m_b2g(input int x);
    return W'(x ^ (x >> 1));
  endfunction

  function automatic logic [W-1:0] m_g2b(input logic [W-1:0] g);
    for (int b = 0; b < (1 << W); b++) begin
      if (m_b2g(b) == g) return W'(b);
    end
    return '0;
  endfunction

  function automatic int m_popcount(input logic [W-1:0] x);
    int n = 0;
    for (int i = 0; i < W; i++) n += int'(x[i]);
    return n;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_err   = 1'b0;
    m_cnt   = 0;
    m_last  = '0;
    m_first = 1'b1;
  endtask

  task automatic drive(input bit v, input logic [1:0] md, input logic [W-1:0] d,
                       input bit rdy);
    in_valid  = v;
    mode      = md;
    in_data   = d;
    out_ready = rdy;
    #1;
  endtask

  // Advance one clock edge and apply the same edge to the model.
  task automatic tick();
    bit acc;
    acc = in_valid && (!m_valid || out_ready);
    @(posedge clk);
    if (acc) begin
      m_valid = 1'b1;
      m_err   = 1'b0;
      case (mode)
        2'b00: m_data = m_g2b(in_data);
        2'b01: m_data = m_b2g(int'(in_data));
        2'b10: begin
          m_data = m_b2g(m_cnt);
          m_cnt  = (m_cnt + 1) % (1 << W);
        end
        default: begin
          m_data  = in_data;
          m_err   = !m_first && (m_popcount(in_data ^ m_last) != 1);
          m_last  = in_data;
          m_first = 1'b0;
        end
      endcase
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    in_valid = 1'b0;
    out_ready = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%b d=%h e=%b want v=0 d=0 e=0",
               out_valid, out_data, out_err);
    end
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset: got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid);
    end
  endtask

  task automatic test_g2b();
    drive(1'b1, MODE_G2B, 4'b1011, 1'b1);
    tick();
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== 4'b1101 || out_err !== 1'b0) begin
      n_err++;
      $display("FAIL g2b_1011: got v=%b d=%b e=%b want v=1 d=1101 e=0",
               out_valid, out_data, out_err);
    end
    drive(1'b0, MODE_G2B, '0, 1'b1);
    tick();
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL g2b_drain: got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] g;
    for (int v = 0; v < (1 << W); v++) begin
      g = m_b2g(v);
      drive(1'b1, MODE_B2G, W'(v), 1'b1);
      tick();
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== g) begin
        n_err++;
        $display("FAIL b2g_%0d: got v=%b d=%b want v=1 d=%b", v, out_valid, out_data, g);
      end
      if (v == 5) begin
        n_vec++;
        if (out_data !== 4'b0111) begin
          n_err++;
          $display("FAIL b2g_5_const: got %b want 0111", out_data);
        end
      end
      drive(1'b1, MODE_G2B, g, 1'b1);
      tick();
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== W'(v)) begin
        n_err++;
        $display("FAIL roundtrip_%0d: got v=%b d=%h want v=1 d=%h", v, out_valid, out_data, v);
      end
    end
    drive(1'b0, MODE_G2B, '0, 1'b1);
    tick();
  endtask

  task automatic test_count();
    int exp_tab[17] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 0};
    do_reset();
    for (int k = 0; k < 17; k++) begin
      drive(1'b1, MODE_COUNT, W'($urandom), 1'b1);
      tick();
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== W'(exp_tab[k]) || out_data !== m_data) begin
        n_err++;
        $display("FAIL count_%0d: got v=%b d=%0d want v=1 d=%0d", k, out_valid, out_data,
                 exp_tab[k]);
      end
    end
    drive(1'b0, MODE_COUNT, '0, 1'b1);
    tick();
  endtask

  task automatic test_backpressure();
    drive(1'b1, MODE_B2G, 4'd3, 1'b1);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, MODE_B2G, 4'd9, 1'b0);
      n_vec++;
      if (in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL bp_in_ready_%0d: got %b want 0", k, in_ready);
      end
      tick();
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== 4'd2) begin
        n_err++;
        $display("FAIL bp_hold_%0d: got v=%b d=%h want v=1 d=2", k, out_valid, out_data);
      end
    end
    drive(1'b1, MODE_B2G, 4'd9, 1'b1);
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL bp_resume_ready: got %b want 1", in_ready);
    end
    tick();
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== 4'd13) begin
      n_err++;
      $display("FAIL bp_resume_data: got v=%b d=%h want v=1 d=d", out_valid, out_data);
    end
    drive(1'b0, MODE_B2G, '0, 1'b1);
    tick();
  endtask

  task automatic test_check();
    logic [W-1:0] ins[5] = '{4'b0000, 4'b0001, 4'b0011, 4'b0000, 4'b0100};
    logic         errs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, MODE_CHECK, ins[k], 1'b1);
      tick();
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== ins[k] || out_err !== errs[k]) begin
        n_err++;
        $display("FAIL check_%0d: got d=%b e=%b want d=%b e=%b", k, out_data, out_err,
                 ins[k], errs[k]);
      end
    end
    drive(1'b0, MODE_CHECK, '0, 1'b1);
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, MODE_COUNT, '0, 1'b1);
      tick();
    end
    drive(1'b1, MODE_COUNT, '0, 1'b0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || out_data !== '0) begin
      n_err++;
      $display("FAIL reset_mid_async: got v=%b d=%h want v=0 d=0", out_valid, out_data);
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b1, MODE_COUNT, '0, 1'b1);
    tick();
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== '0) begin
      n_err++;
      $display("FAIL reset_mid_count: got v=%b d=%h want v=1 d=0", out_valid, out_data);
    end
    drive(1'b0, MODE_COUNT, '0, 1'b1);
    tick();
  endtask

  task automatic test_random();
    bit rdy;
    for (int k = 0; k < 400; k++) begin
      rdy = ($urandom_range(0, 3) != 0);
      drive(($urandom_range(0, 3) != 0), 2'($urandom), W'($urandom), rdy);
      n_vec++;
      if (in_ready !== (!m_valid || rdy)) begin
        n_err++;
        $display("FAIL rand_in_ready_%0d: got %b want %b", k, in_ready, (!m_valid || rdy));
      end
      tick();
      n_vec++;
      if (out_valid !== m_valid ||
          (m_valid && (out_data !== m_data || out_err !== m_err))) begin
        n_err++;
        $display("FAIL rand_out_%0d: got v=%b d=%h e=%b want v=%b d=%h e=%b", k,
                 out_valid, out_data, out_err, m_valid, m_data, m_err);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_g2b();
    test_back_to_back();
    test_count();
    test_backpressure();
    test_check();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gray_codec_stream.md
GRAY_CODEC_STREAM -- requirements
Module: gray_codec_stream

Interface
REQ-001 The block SHALL have parameter W, default 8, meaning data width in bits (legal 2..32).
REQ-002 The block SHALL have port clk, input, 1, meaning the single clock; all state on rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-004 The block SHALL have port mode, input, 2, meaning operation select, sampled with each accepted input token.
REQ-005 The block SHALL have port in_valid, input, 1, meaning in_data/mode hold a token.
REQ-006 The block SHALL have port in_ready, output, 1, meaning the block accepts a token this cycle.
REQ-007 The block SHALL have port in_data, input, W, meaning the operand.
REQ-008 The block SHALL have port out_valid, output, 1, meaning out_data/out_err hold a result.
REQ-009 The block SHALL have port out_ready, input, 1, meaning the consumer takes the result this cycle.
REQ-010 The block SHALL have port out_data, output, W, meaning the result.
REQ-011 The block SHALL have port out_err, output, 1, meaning the check-mode flag; 0 in other modes.

Function
REQ-012 Accept SHALL occur when in_valid and in_ready are both 1; transfer SHALL occur when out_valid and out_ready are both 1.
REQ-013 in_ready SHALL equal (!out_valid || out_ready), combinationally; a one-entry output register, full throughput.
REQ-014 Latency SHALL be one cycle: the result of a token accepted at edge k is visible from edge k with out_valid=1.
REQ-015 The output register SHALL hold out_data/out_err stable while out_valid=1 and out_ready=0.
REQ-016 When a transfer occurs with no accept in the same cycle, out_valid SHALL drop to 0.
REQ-017 mode 00 (G2B) SHALL compute out_data[W-1]=in_data[W-1], out_data[i]=out_data[i+1]^in_data[i].
REQ-018 mode 01 (B2G) SHALL compute out_data = in_data ^ (in_data >> 1).
REQ-019 mode 10 (COUNT) SHALL output Gray(cnt), then cnt <= cnt+1 modulo 2^W; in_data is ignored.
REQ-020 Counter wrap SHALL be silent: after Gray(2^W-1), the next COUNT output is 0.
REQ-021 mode 11 (CHECK) SHALL pass in_data to out_data unchanged and set out_err=1 when popcount(in_data ^ last_chk) != 1.
REQ-022 last_chk SHALL update to in_data on every CHECK accept, including erroneous ones.
REQ-023 The first CHECK accept after reset SHALL give out_err=0 and only load last_chk; a first-flag register tracks this.
REQ-024 cnt and last_chk SHALL change only on accepts of their own mode; other modes leave them untouched.
REQ-025 Modes MAY change token to token with no bubble; each token uses the mode it was accepted with.

Reset
REQ-026 rst_n low SHALL asynchronously clear out_valid=0, out_data=0, out_err=0, cnt=0, last_chk=0 and first-flag=1.
REQ-027 in_ready SHALL be 1 during and directly after reset; a token in flight at reset is discarded.
REQ-028 Reset release SHALL be usable synchronously to clk; no accept takes effect on the releasing edge's setup violation.

Structure
REQ-029 A shared package gray_pkg SHALL hold the 2-bit mode constants (MODE_G2B, MODE_B2G, MODE_COUNT, MODE_CHECK).
REQ-030 One combinational sub-module gray_bin_xor, parametrised by W with a direction input, SHALL implement REQ-017/018 and be used for B2G, COUNT and G2B.
REQ-031 All sequential logic (output register, cnt, last_chk, first-flag) SHALL live in gray_codec_stream; the output stage is implementable in 120-400 lines total.

Verification (W=4)
REQ-032 G2B: stream 4'b1011 with out_ready=1 -> next cycle out_data=4'b1101, out_valid=1, out_err=0.
REQ-033 B2G then G2B back-to-back on all 16 values -> B2G(5)=4'b0111; round trip returns each input, no bubbles.
REQ-034 COUNT: 17 tokens after reset -> outputs 0,1,3,2,6,7,5,4,12,13,15,14,10,11,9,8, then 0 (wrap).
REQ-035 Backpressure: out_ready=0 for 3 cycles with out_valid=1 -> in_ready=0, out_data stable, no token lost; resumes on out_ready=1.
REQ-036 CHECK: inputs 0000,0001,0011,0000 -> out_err 0,0,0,1; a following 0100 -> out_err 0.
REQ-037 Reset mid-stream: rst_n low while out_valid=1 and cnt=5 -> out_valid=0 immediately; the next COUNT output is 0.
